// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master drives operands and result acceptance; the slave (divider) returns results.
interface seq_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, MSB first.
// state | meaning
// IDLE  | ready for operands; capture on in_valid
// BUSY  | one restoring step per cycle, DW steps in total
// DONE  | result presented until out_ready
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] cnt;
    logic [DW-1:0] work;
    logic [VW-1:0] dvs;
    logic [VW-1:0] rem;

    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;
    logic          dbz_q;

    logic [VW:0]   partial;
    logic          take;
    logic [VW-1:0] rem_step;
    logic [DW-1:0] work_step;
    logic          last_step;

    // Dividend bits shift out of the top of work while quotient bits shift into the bottom.
    always_comb begin
        partial   = {rem, work[DW-1]};
        take      = (partial >= {1'b0, dvs});
        rem_step  = take ? (partial[VW-1:0] - dvs) : partial[VW-1:0];
        work_step = {work[DW-2:0], take};
        last_step = (cnt == CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = (bus.divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers load only when a new result is produced, so they hold across the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            work  <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work <= bus.dividend;
                        dvs  <= bus.divisor;
                        rem  <= '0;
                        if (bus.divisor == '0) begin
                            cnt   <= '0;
                            quo_q <= '1;
                            rem_q <= '0;
                            dbz_q <= 1'b1;
                        end else begin
                            cnt <= CW'(DW);
                        end
                    end
                end
                BUSY: begin
                    work <= work_step;
                    rem  <= rem_step;
                    cnt  <= cnt - CW'(1);
                    if (last_step) begin
                        quo_q <= work_step;
                        rem_q <= rem_step;
                        dbz_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expectations queued at acceptance, compared on the result handshake.
module tb_seq_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    exp_t sb[$];

    seq_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Result monitor: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_result", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                chk("quotient", bus.quotient, e.q);
                chk("remainder", bus.remainder, e.r);
                chk("div_by_zero", bus.div_by_zero, e.z);
                if (e.b != '0) begin
                    chk("invariant", int'(bus.quotient) * int'(e.b) + int'(bus.remainder), e.a);
                    chk("rem_lt_div", bus.remainder < e.b, 1);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q = '1;
            e.r = '0;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = VW'($urandom);
    endtask

    task automatic wait_result();
        int start;
        int n;
        start = pops;
        n = 0;
        while (pops == start && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("result_wait", pops - start, 1);
    endtask

    task automatic run_timed(input logic [DW-1:0] a, input logic [VW-1:0] b, input int lat);
        send(a, b);
        for (int i = 1; i < lat; i++) begin
            chk("latency_low", bus.out_valid, 0);
            @(posedge clk);
            #1;
        end
        chk("latency_high", bus.out_valid, 1);
        @(posedge clk);
        #1;
        chk("back_idle", bus.in_ready, 1);
    endtask

    initial begin
        int ghost;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        #22;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_timed(8'd200, 4'd7, 9);
        run_timed(8'd255, 4'd1, 9);
        run_timed(8'd9, 4'd15, 9);
        run_timed(8'd0, 4'd5, 9);
        run_timed(8'd255, 4'd15, 9);

        run_timed(8'd100, 4'd0, 1);
        chk("dbz_held", bus.div_by_zero, 1);
        chk("dbz_quo_held", bus.quotient, 8'hFF);
        run_timed(8'd12, 4'd4, 9);

        for (int a = 10; a <= 15; a++) begin
            for (int b = 1; b <= 5; b++) begin
                send(DW'(a * b), VW'(b));
                wait_result();
            end
        end

        for (int i = 0; i < 500; i++) begin
            send(DW'($urandom), VW'($urandom_range(0, 15)));
            wait_result();
        end

        bus.out_ready = 1'b0;
        send(8'd100, 4'd9);
        for (int n = 0; n < 30 && !bus.out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = i[0];
            bus.dividend = DW'($urandom);
            bus.divisor  = VW'($urandom);
            @(posedge clk);
            #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_quotient", bus.quotient, 11);
            chk("bp_remainder", bus.remainder, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_sb_empty", sb.size(), 0);

        send(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ghost = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) ghost++;
        end
        chk("abort_no_result", ghost, 0);
        send(8'd50, 4'd6);
        wait_result();

        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
